// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM arbiter: command encodings, one-hot state
// encoding and default bus widths.
package sdram_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int BA_W_DEF   = 2;
   localparam int DQ_W_DEF   = 16;

   // {CS,RAS,CAS,WE}, active low
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_ARBIT = 5'b00010,
      ST_AREF  = 5'b00100,
      ST_WRITE = 5'b01000,
      ST_READ  = 5'b10000
   } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// Client-side request/bus signals and SDRAM pad-side command bus of the arbiter.
interface sdram_arbit_if #(
   parameter int ADDR_W = sdram_pkg::ADDR_W_DEF,
   parameter int BA_W   = sdram_pkg::BA_W_DEF,
   parameter int DQ_W   = sdram_pkg::DQ_W_DEF
);
   logic              flag_init_end;
   logic [3:0]        init_cmd;
   logic [ADDR_W-1:0] init_addr;

   logic              ref_req, flag_ref_end;
   logic [3:0]        ref_cmd;
   logic [ADDR_W-1:0] ref_addr;

   logic              wr_req, flag_wr_end;
   logic [3:0]        wr_cmd;
   logic [ADDR_W-1:0] wr_addr;
   logic [BA_W-1:0]   wr_bank;
   logic              wr_dq_oe;
   logic [DQ_W-1:0]   wr_data;

   logic              rd_req, flag_rd_end;
   logic [3:0]        rd_cmd;
   logic [ADDR_W-1:0] rd_addr;
   logic [BA_W-1:0]   rd_bank;

   logic              ref_en, wr_en, rd_en;
   logic [3:0]        sdram_cmd;
   logic [ADDR_W-1:0] sdram_addr;
   logic [BA_W-1:0]   sdram_bank;
   logic              sdram_dq_oe;
   logic [DQ_W-1:0]   sdram_dq_out;

   modport slave (
      input  flag_init_end, init_cmd, init_addr,
      input  ref_req, flag_ref_end, ref_cmd, ref_addr,
      input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_dq_oe, wr_data,
      input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
      output ref_en, wr_en, rd_en,
      output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out
   );

   modport master (
      output flag_init_end, init_cmd, init_addr,
      output ref_req, flag_ref_end, ref_cmd, ref_addr,
      output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_dq_oe, wr_data,
      output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
      input  ref_en, wr_en, rd_en,
      input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out
   );
endinterface

// File: rtl/sdram_bus_mux.sv
// Combinational SDRAM command/address/bank/oe select driven by arbiter state.
module sdram_bus_mux
   import sdram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BA_W   = BA_W_DEF
) (
   input  arb_state_t        state,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [3:0]        ref_cmd,
   input  logic [ADDR_W-1:0] ref_addr,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BA_W-1:0]   wr_bank,
   input  logic              wr_dq_oe,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BA_W-1:0]   rd_bank,
   output logic [3:0]        sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BA_W-1:0]   sdram_bank,
   output logic              sdram_dq_oe
);

   always_comb begin
      sdram_cmd   = CMD_NOP;
      sdram_addr  = '0;
      sdram_bank  = '0;
      sdram_dq_oe = 1'b0;
      case (state)
         ST_IDLE: begin
            sdram_cmd  = init_cmd;
            sdram_addr = init_addr;
         end
         ST_AREF: begin
            sdram_cmd  = ref_cmd;
            sdram_addr = ref_addr;
         end
         ST_WRITE: begin
            sdram_cmd   = wr_cmd;
            sdram_addr  = wr_addr;
            sdram_bank  = wr_bank;
            sdram_dq_oe = wr_dq_oe;
         end
         ST_READ: begin
            sdram_cmd  = rd_cmd;
            sdram_addr = rd_addr;
            sdram_bank = rd_bank;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: init -> fixed-priority refresh/write/read grants.
// Define SDRAM_ARB_RR_EN to alternate write/read when both are pending.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BA_W   = BA_W_DEF,
   parameter int DQ_W   = DQ_W_DEF
) (
   input  logic          sclk,
   input  logic          reset,
   sdram_arbit_if.slave  bus
);

   arb_state_t state, state_nxt;
   logic       wr_pick;

`ifdef SDRAM_ARB_RR_EN
   // 1 = read was served last; reset value lets write go first
   logic last_rd;

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset)
         last_rd <= 1'b1;
      else if (state == ST_ARBIT && state_nxt == ST_WRITE)
         last_rd <= 1'b0;
      else if (state == ST_ARBIT && state_nxt == ST_READ)
         last_rd <= 1'b1;
   end

   assign wr_pick = bus.wr_req && (!bus.rd_req || last_rd);
`else
   assign wr_pick = bus.wr_req;
`endif

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.flag_init_end) state_nxt = ST_ARBIT;
         ST_ARBIT: begin
            if (bus.ref_req)     state_nxt = ST_AREF;
            else if (wr_pick)    state_nxt = ST_WRITE;
            else if (bus.rd_req) state_nxt = ST_READ;
         end
         ST_AREF:  if (bus.flag_ref_end) state_nxt = ST_ARBIT;
         ST_WRITE: if (bus.flag_wr_end)  state_nxt = ST_ARBIT;
         ST_READ:  if (bus.flag_rd_end)  state_nxt = ST_ARBIT;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign bus.ref_en       = (state == ST_AREF);
   assign bus.wr_en        = (state == ST_WRITE);
   assign bus.rd_en        = (state == ST_READ);
   assign bus.sdram_dq_out = bus.wr_data;

   sdram_bus_mux #(.ADDR_W(ADDR_W), .BA_W(BA_W)) u_mux (
      .state       (state),
      .init_cmd    (bus.init_cmd),
      .init_addr   (bus.init_addr),
      .ref_cmd     (bus.ref_cmd),
      .ref_addr    (bus.ref_addr),
      .wr_cmd      (bus.wr_cmd),
      .wr_addr     (bus.wr_addr),
      .wr_bank     (bus.wr_bank),
      .wr_dq_oe    (bus.wr_dq_oe),
      .rd_cmd      (bus.rd_cmd),
      .rd_addr     (bus.rd_addr),
      .rd_bank     (bus.rd_bank),
      .sdram_cmd   (bus.sdram_cmd),
      .sdram_addr  (bus.sdram_addr),
      .sdram_bank  (bus.sdram_bank),
      .sdram_dq_oe (bus.sdram_dq_oe)
   );

endmodule

// File: tb/tb_sdram_arbit.sv
// Table-driven bench for sdram_arbit with an expected-state scoreboard queue.
module tb_sdram_arbit;
   import sdram_pkg::*;

   localparam int ADDR_W = 12;
   localparam int BA_W   = 2;
   localparam int DQ_W   = 16;

   typedef enum int {S_IDLE, S_ARBIT, S_AREF, S_WRITE, S_READ} st_e;

   typedef struct {
      logic  init_end, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end;
      st_e   exp;
      string name;
   } vec_t;

   typedef struct {
      st_e   st;
      string name;
   } sb_t;

   logic sclk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;
   vec_t vecs[21];
   sb_t  sb[$];

   sdram_arbit_if #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

   sdram_arbit #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
      .sclk  (sclk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 sclk = ~sclk;

   function automatic vec_t mk(input logic ie, rq_ref, rq_wr, rq_rd, e_ref, e_wr, e_rd,
                               input st_e ex, input string nm);
      vec_t v;
      v.init_end = ie; v.ref_req = rq_ref; v.wr_req = rq_wr; v.rd_req = rq_rd;
      v.ref_end = e_ref; v.wr_end = e_wr; v.rd_end = e_rd; v.exp = ex; v.name = nm;
      return v;
   endfunction

   task automatic check(input st_e st, input string nm);
      logic [37:0] exp, act;
      exp = '0;
      exp[15:0] = bus.wr_data;
      case (st)
         S_IDLE:  exp[37:16] = {3'b000, bus.init_cmd, bus.init_addr, 2'b00, 1'b0};
         S_ARBIT: exp[37:16] = {3'b000, CMD_NOP, 12'h000, 2'b00, 1'b0};
         S_AREF:  exp[37:16] = {3'b100, bus.ref_cmd, bus.ref_addr, 2'b00, 1'b0};
         S_WRITE: exp[37:16] = {3'b010, bus.wr_cmd, bus.wr_addr, bus.wr_bank, bus.wr_dq_oe};
         default: exp[37:16] = {3'b001, bus.rd_cmd, bus.rd_addr, bus.rd_bank, 1'b0};
      endcase
      act = {bus.ref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_addr,
             bus.sdram_bank, bus.sdram_dq_oe, bus.sdram_dq_out};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (state %s)", nm, act, exp, st.name());
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply_vec(input vec_t v);
      sb_t e;
      bus.flag_init_end = v.init_end;
      bus.ref_req = v.ref_req; bus.wr_req = v.wr_req; bus.rd_req = v.rd_req;
      bus.flag_ref_end = v.ref_end; bus.flag_wr_end = v.wr_end; bus.flag_rd_end = v.rd_end;
      bus.wr_data = 16'($urandom);
      sb.push_back('{st: v.exp, name: v.name});
      @(posedge sclk);
      @(negedge sclk);
      e = sb.pop_front();
      check(e.st, e.name);
   endtask

   initial begin
      reset = 1'b0;
      bus.init_cmd = CMD_PRE;  bus.init_addr = 12'h111;
      bus.ref_cmd  = CMD_AREF; bus.ref_addr  = 12'h222;
      bus.wr_cmd   = CMD_WR;   bus.wr_addr   = 12'h333; bus.wr_bank = 2'd1;
      bus.rd_cmd   = CMD_RD;   bus.rd_addr   = 12'h444; bus.rd_bank = 2'd2;
      bus.wr_dq_oe = 1'b1;     bus.wr_data   = 16'h0;
      bus.flag_init_end = 1'b0;
      bus.ref_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      bus.flag_ref_end = 1'b0; bus.flag_wr_end = 1'b0; bus.flag_rd_end = 1'b0;

      //                ie ref wr rd  re we de
      vecs[0]  = mk(0, 0, 1, 0, 0, 0, 0, S_IDLE,  "idle_ignores_req");
      vecs[1]  = mk(1, 0, 1, 0, 0, 0, 0, S_ARBIT, "init_to_arbit");
      vecs[2]  = mk(1, 0, 1, 0, 0, 0, 0, S_WRITE, "grant_write");
      vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, S_WRITE, "write_held_req_low");
      vecs[4]  = mk(1, 1, 0, 0, 1, 0, 1, S_WRITE, "write_ignores_other_ends");
      vecs[5]  = mk(1, 1, 0, 0, 0, 1, 0, S_ARBIT, "write_end");
      vecs[6]  = mk(1, 1, 0, 0, 0, 0, 0, S_AREF,  "refresh_after_write");
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, S_AREF,  "init_end_fall_ignored");
      vecs[8]  = mk(0, 0, 0, 0, 1, 0, 0, S_ARBIT, "ref_end");
      vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, S_ARBIT, "arbit_no_req");
      vecs[10] = mk(1, 1, 1, 1, 0, 0, 0, S_AREF,  "all_req_ref_first");
      vecs[11] = mk(1, 0, 1, 1, 1, 0, 0, S_ARBIT, "all_ref_end");
      vecs[12] = mk(1, 0, 1, 1, 0, 0, 0, S_WRITE, "all_write_second");
      vecs[13] = mk(1, 0, 0, 1, 0, 1, 0, S_ARBIT, "all_wr_end");
      vecs[14] = mk(1, 0, 0, 1, 0, 0, 0, S_READ,  "all_read_third");
      vecs[15] = mk(1, 1, 0, 1, 0, 0, 0, S_READ,  "read_no_preempt");
      vecs[16] = mk(1, 1, 0, 0, 0, 0, 1, S_ARBIT, "read_end");
      vecs[17] = mk(1, 1, 0, 0, 0, 0, 0, S_AREF,  "refresh_after_read");
      vecs[18] = mk(1, 0, 0, 1, 1, 0, 0, S_ARBIT, "ref_end_rd_pulse");
      vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, S_ARBIT, "rd_pulse_lost");
      vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, S_ARBIT, "arbit_quiet");

      // Held in reset with write pending and no init: nothing may be granted.
      for (int i = 0; i < 20; i++)
         apply_vec(mk(0, 0, 1, 0, 0, 0, 0, S_IDLE, "reset_hold"));
      reset = 1'b1;

      for (int i = 0; i < 21; i++) apply_vec(vecs[i]);

      // Both write and read held: alternate with round robin, else write wins.
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_WRITE, "both_1"));
      apply_vec(mk(1, 0, 1, 1, 0, 1, 1, S_ARBIT, "both_1_end"));
`ifdef SDRAM_ARB_RR_EN
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_READ,  "both_2"));
      apply_vec(mk(1, 0, 1, 1, 0, 1, 1, S_ARBIT, "both_2_end"));
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_WRITE, "both_3"));
      apply_vec(mk(1, 0, 1, 1, 0, 1, 1, S_ARBIT, "both_3_end"));
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_READ,  "both_4"));
`else
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_WRITE, "both_2"));
      apply_vec(mk(1, 0, 1, 1, 0, 1, 1, S_ARBIT, "both_2_end"));
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_WRITE, "both_3"));
      apply_vec(mk(1, 0, 1, 1, 0, 1, 1, S_ARBIT, "both_3_end"));
      apply_vec(mk(1, 0, 1, 1, 0, 0, 0, S_WRITE, "both_4"));
`endif
      apply_vec(mk(1, 0, 0, 0, 1, 1, 1, S_ARBIT, "both_done"));

      // Mid-WRITE async reset: outputs must drop with no clock edge.
      apply_vec(mk(1, 0, 1, 0, 0, 0, 0, S_WRITE, "pre_async_write"));
      bus.wr_dq_oe = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check(S_IDLE, "async_reset_mid_write");
      bus.flag_init_end = 1'b0;
      apply_vec(mk(0, 1, 1, 1, 0, 0, 0, S_IDLE, "in_reset_idle"));
      reset = 1'b1;
      apply_vec(mk(0, 1, 1, 1, 0, 0, 0, S_IDLE, "post_reset_no_init"));
      apply_vec(mk(1, 0, 1, 0, 0, 0, 0, S_ARBIT, "post_reset_arbit"));
      apply_vec(mk(1, 0, 1, 0, 0, 0, 0, S_WRITE, "post_reset_write"));
      apply_vec(mk(1, 0, 0, 0, 0, 1, 0, S_ARBIT, "post_reset_wr_end"));

      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter ADDR_W, default 12, SDRAM address bus width.
REQ-002 Parameter BA_W, default 2, bank address width.
REQ-003 Parameter DQ_W, default 16, SDRAM data width.
REQ-004 sclk  in  1  single clock; every register uses its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 flag_init_end  in  1  level; power-up init sequence finished.
REQ-007 init_cmd / init_addr  in  4 / ADDR_W  init-sequencer command and address.
REQ-008 ref_req, flag_ref_end, ref_cmd, ref_addr  in  1,1,4,ADDR_W  refresh request, end pulse, command, address.
REQ-009 wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank  in  1,1,4,ADDR_W,BA_W  writer request, end pulse, bus drive.
REQ-010 wr_dq_oe, wr_data  in  1, DQ_W  writer data output enable and data.
REQ-011 rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank  in  1,1,4,ADDR_W,BA_W  reader request, end pulse, bus drive.
REQ-012 ref_en, wr_en, rd_en  out  1 each  grants; at most one high.
REQ-013 sdram_cmd, sdram_addr, sdram_bank  out  4, ADDR_W, BA_W  SDRAM command bus {CS,RAS,CAS,WE}.
REQ-014 sdram_dq_oe, sdram_dq_out  out  1, DQ_W  tristate control and write data to the pad.

Function
REQ-015 FSM states: IDLE, ARBIT, AREF, WRITE, READ; one-hot; encoding held in the shared package.
REQ-016 IDLE -> ARBIT on the first edge with flag_init_end=1; all requests are ignored in IDLE.
REQ-017 ARBIT, fixed priority: ref_req -> AREF, else wr_req -> WRITE, else rd_req -> READ, else stay in ARBIT; decision takes one cycle.
REQ-018 AREF/WRITE/READ return to ARBIT on the edge where their own flag_*_end=1; end flags of other clients are ignored.
REQ-019 ref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ): Moore decode of the state register, no extra latency.
REQ-020 A grant deasserts in the cycle after its end pulse; a client stays granted while its end flag is low, even if its request has dropped.
REQ-021 Bus mux, combinational from the state register: IDLE=init_*, AREF=ref_*, WRITE=wr_*, READ=rd_*, ARBIT=NOP (4'b0111) with address 0.
REQ-022 sdram_bank=0 in IDLE, AREF and ARBIT.
REQ-023 sdram_dq_oe=wr_dq_oe only in WRITE, else 0.
REQ-024 sdram_dq_out=wr_data at all times.
REQ-025 ref_req arriving during WRITE/READ causes no preemption; the client itself yields via its end flag, and the refresh is then granted from ARBIT.
REQ-026 Simultaneous ref_req+wr_req+rd_req in ARBIT: AREF; after flag_ref_end, WRITE; then READ.
REQ-027 A request pulse that drops before ARBIT samples it is lost; requests are expected to be held levels.
REQ-028 flag_init_end falling after IDLE is ignored.

Reset
REQ-029 On reset low, immediately (async) and mid-operation: state=IDLE; all grants 0; sdram_cmd follows init_cmd; sdram_dq_oe=0.
REQ-030 On reset low, the round-robin pointer (if built) is set to "read last served".
REQ-031 Leaving reset, the first transition is IDLE->ARBIT only; no grant issues without flag_init_end.

Configuration
REQ-032 Macro SDRAM_ARB_RR_EN defined: when wr_req and rd_req are both pending without ref_req in ARBIT, grant the client not served last; a 1-bit last_served register updates on each WRITE/READ entry.
REQ-033 Macro SDRAM_ARB_RR_EN undefined: fixed write-over-read priority per REQ-017; no pointer register is built.

Structure
REQ-034 Shared package sdram_pkg holds: CMD_NOP/PRE/AREF/ACT/WR/RD/MRS constants; arbiter state encoding; ADDR_W/BA_W defaults.
REQ-035 One sub-module is natural: sdram_bus_mux (state -> cmd/addr/bank/dq_oe select, purely combinational); FSM and pointer stay in sdram_arbit.

Verification
REQ-036 Reset low, flag_init_end=0, wr_req=1 for 20 cycles -> state IDLE, wr_en=0, sdram_cmd=init_cmd.
REQ-037 flag_init_end=1, then wr_req=1 -> ARBIT next edge, wr_en=1 the edge after; flag_wr_end pulse -> wr_en=0 the next cycle.
REQ-038 ref_req, wr_req and rd_req all set in the same cycle -> grant order ref_en, wr_en, rd_en, each held until its own end pulse.
REQ-039 rd_en active, ref_req raised -> rd_en stays 1 until flag_rd_end, then ARBIT, then ref_en=1.
REQ-040 SDRAM_ARB_RR_EN, wr_req and rd_req held high -> grants alternate W,R,W,R.
REQ-041 Reset asserted mid-WRITE with wr_dq_oe=1 -> sdram_dq_oe=0 and wr_en=0 asynchronously, with no clock edge.
